// File: rtl/vga_line_doubler_pkg.sv
// Shared VGA 640x480@60 timing constants, line-buffer geometry and pixel type
// for the NES line doubler.
package vga_timing_pkg;

  typedef logic [9:0] cnt_t;
  typedef logic [23:0] rgb_t;

  localparam cnt_t H_ACTIVE = 10'd640;
  localparam cnt_t H_FP     = 10'd16;
  localparam cnt_t H_SYNC   = 10'd96;
  localparam cnt_t H_BP     = 10'd48;
  localparam cnt_t H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam cnt_t HS_START = H_ACTIVE + H_FP;
  localparam cnt_t HS_END   = HS_START + H_SYNC;

  localparam cnt_t V_ACTIVE = 10'd480;
  localparam cnt_t V_FP     = 10'd10;
  localparam cnt_t V_SYNC   = 10'd2;
  localparam cnt_t V_BP     = 10'd33;
  localparam cnt_t V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam cnt_t VS_START = V_ACTIVE + V_FP;
  localparam cnt_t VS_END   = VS_START + V_SYNC;

  localparam logic [8:0] SRC_WIDTH = 9'd256;
  localparam logic [8:0] SRC_LAST  = SRC_WIDTH - 9'd1;

  localparam cnt_t H_OFFSET = 10'd64;
  localparam cnt_t PIC_END  = H_OFFSET + 10'd512;

  localparam rgb_t BORDER_RGB = 24'h000000;

  // Two banks of one NES scanline each; bank select is the top address bit.
  localparam int RAM_DEPTH = 512;

  // Halve each 8-bit channel independently so no bit leaks across channels.
  function automatic rgb_t scanline_dim(rgb_t c);
    return (c >> 1) & 24'h7F7F7F;
  endfunction

endpackage

// File: rtl/vga_line_doubler_if.sv
// Bundles for the NES pixel stream and the ping-pong line RAM bus.
// Pixel stream: a pixel is taken on every clock where valid is high; there is no ready.
interface vga_pixel_if;
  logic                 valid;
  logic [8:0]           x;
  vga_timing_pkg::rgb_t rgb;

  modport master (output valid, x, rgb);
  modport slave  (input  valid, x, rgb);
endinterface

interface vga_line_ram_if;
  logic                 we;
  logic                 wbank;
  logic [7:0]           waddr;
  vga_timing_pkg::rgb_t wdata;
  logic                 rbank;
  logic [7:0]           raddr;
  vga_timing_pkg::rgb_t rdata;

  modport master (output we, wbank, waddr, wdata, rbank, raddr, input rdata);
  modport slave  (input we, wbank, waddr, wdata, rbank, raddr, output rdata);
endinterface

// File: rtl/vga_line_doubler_line_ram.sv
// Two-bank scanline RAM: synchronous write, registered read.
// A same-cycle write and read of one location returns the old data.
module vga_line_ram
  import vga_timing_pkg::*;
(
  input logic          clk,
  vga_line_ram_if.slave bus
);

  rgb_t mem [RAM_DEPTH];

  always_ff @(posedge clk) begin
    if (bus.we) begin
      mem[{bus.wbank, bus.waddr}] <= bus.wdata;
    end
    bus.rdata <= mem[{bus.rbank, bus.raddr}];
  end

endmodule

// File: rtl/vga_line_doubler.sv
// Buffers NES scanlines in ping-pong RAM and shows them 2x scaled and centred on 640x480@60.
// Build option: VGA_SCANLINES_EN dims odd lines of the picture to half intensity.
module vga_line_doubler
  import vga_timing_pkg::*;
(
  input  logic       i_clk_25mhz,
  input  logic       i_reset_n,
  input  logic       i_pixel_valid,
  input  logic [8:0] i_pixel_x,
  input  rgb_t       i_pixel_rgb,
  output logic       o_vga_hsync,
  output logic       o_vga_vsync,
  output logic       o_vga_de,
  output rgb_t       o_vga_rgb,
  output logic       o_overrun
);

  // ---------------------------------------------------------------- timing
  cnt_t h_cnt;
  cnt_t v_cnt;
  logic h_last;
  logic v_last;

  assign h_last = (h_cnt == H_TOTAL - 10'd1);
  assign v_last = (v_cnt == V_TOTAL - 10'd1);

  always_ff @(posedge i_clk_25mhz or negedge i_reset_n) begin
    if (!i_reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  // ---------------------------------------------------------------- write side
  vga_line_ram_if ram_bus ();

  logic wbank;
  logic done_bank;
  logic overrun;
  logic x_in_range;
  logic x_last;

  assign x_in_range = (i_pixel_x < SRC_WIDTH);
  assign x_last     = (i_pixel_x == SRC_LAST);

  always_ff @(posedge i_clk_25mhz or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wbank     <= 1'b0;
      done_bank <= 1'b0;
      overrun   <= 1'b0;
    end else if (i_pixel_valid) begin
      if (x_last) begin
        done_bank <= wbank;
        wbank     <= ~wbank;
      end
      if (!x_in_range) begin
        overrun <= 1'b1;
      end
    end
  end

  assign ram_bus.we    = i_pixel_valid & x_in_range;
  assign ram_bus.wbank = wbank;
  assign ram_bus.waddr = i_pixel_x[7:0];
  assign ram_bus.wdata = i_pixel_rgb;

  // ---------------------------------------------------------------- read side
  logic rbank;
  logic active0;
  logic pic0;
  logic hsync0;
  logic vsync0;

  // The bank only moves at the start of a line pair, so both copies of a
  // source line come from the same buffer even if a new line completes mid-pair.
  always_ff @(posedge i_clk_25mhz or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rbank <= 1'b0;
    end else if ((h_cnt == '0) && (v_cnt < V_ACTIVE) && !v_cnt[0]) begin
      rbank <= done_bank;
    end
  end

  assign active0 = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE);
  assign pic0    = (h_cnt >= H_OFFSET) && (h_cnt < PIC_END) && (v_cnt < V_ACTIVE);
  assign hsync0  = !((h_cnt >= HS_START) && (h_cnt < HS_END));
  assign vsync0  = !((v_cnt >= VS_START) && (v_cnt < VS_END));

  assign ram_bus.rbank = rbank;
  assign ram_bus.raddr = 8'((h_cnt - H_OFFSET) >> 1);

  vga_line_ram u_line_ram (
    .clk (i_clk_25mhz),
    .bus (ram_bus.slave)
  );

  // ---------------------------------------------------------------- pipeline
  // Stage 1 carries the position flags alongside the registered RAM read.
  logic s1_active;
  logic s1_pic;
  logic s1_hsync;
  logic s1_vsync;
`ifdef VGA_SCANLINES_EN
  logic s1_odd;
`endif

  always_ff @(posedge i_clk_25mhz or negedge i_reset_n) begin
    if (!i_reset_n) begin
      s1_active <= 1'b0;
      s1_pic    <= 1'b0;
      s1_hsync  <= 1'b1;
      s1_vsync  <= 1'b1;
`ifdef VGA_SCANLINES_EN
      s1_odd    <= 1'b0;
`endif
    end else begin
      s1_active <= active0;
      s1_pic    <= pic0;
      s1_hsync  <= hsync0;
      s1_vsync  <= vsync0;
`ifdef VGA_SCANLINES_EN
      s1_odd    <= v_cnt[0];
`endif
    end
  end

  rgb_t pic_rgb;
  rgb_t out_rgb;

  always_comb begin
    pic_rgb = ram_bus.rdata;
`ifdef VGA_SCANLINES_EN
    if (s1_odd) begin
      pic_rgb = scanline_dim(ram_bus.rdata);
    end
`endif
    out_rgb = '0;
    if (s1_pic) begin
      out_rgb = pic_rgb;
    end else if (s1_active) begin
      out_rgb = BORDER_RGB;
    end
  end

  always_ff @(posedge i_clk_25mhz or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_vga_hsync <= 1'b1;
      o_vga_vsync <= 1'b1;
      o_vga_de    <= 1'b0;
      o_vga_rgb   <= '0;
    end else begin
      o_vga_hsync <= s1_hsync;
      o_vga_vsync <= s1_vsync;
      o_vga_de    <= s1_active;
      o_vga_rgb   <= out_rgb;
    end
  end

  assign o_overrun = overrun;

endmodule

// File: tb/tb_vga_line_doubler.sv
// Bench for vga_line_doubler: writes NES lines at known VGA positions and
// compares scaled output, border, blanking, sync and overrun against hand values.
module tb_vga_line_doubler;
  import vga_timing_pkg::*;

  // ---------------------------------------------------------------- clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #20 clk = ~clk;

  vga_pixel_if pix ();

  logic hs;
  logic vs;
  logic de;
  rgb_t rgb;
  logic ovr;

  vga_line_doubler dut (
    .i_clk_25mhz   (clk),
    .i_reset_n     (rst_n),
    .i_pixel_valid (pix.valid),
    .i_pixel_x     (pix.x),
    .i_pixel_rgb   (pix.rgb),
    .o_vga_hsync   (hs),
    .o_vga_vsync   (vs),
    .o_vga_de      (de),
    .o_vga_rgb     (rgb),
    .o_overrun     (ovr)
  );

  // Bench's own copy of the raster position being fed into the pipeline.
  int th = 0;
  int tv = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      th <= 0;
      tv <= 0;
    end else if (th == 799) begin
      th <= 0;
      tv <= (tv == 524) ? 0 : tv + 1;
    end else begin
      th <= th + 1;
    end
  end

  // ---------------------------------------------------------------- scoreboard
  typedef struct {
    int          v;
    int          h;
    logic [23:0] rgb;
    logic        de;
  } exp_t;

  exp_t exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(string name, int pv, int ph, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at v=%0d h=%0d actual=%h required=%h", name, pv, ph, act, req);
    end
  endtask

  task automatic push_exp(int v, int h, logic [23:0] c);
    exp_t e;
    e.v   = v;
    e.h   = h;
    e.rgb = c;
    e.de  = (h < 640);
    exp_q.push_back(e);
  endtask

  // Ramp line x -> {0,0,x}: sample columns with hand-computed values.
  int          ramp_h    [12] = '{0, 63, 64, 65, 66, 67, 320, 575, 576, 639, 640, 700};
  logic [23:0] ramp_even [12] = '{24'h0, 24'h0, 24'h000000, 24'h000000, 24'h000001, 24'h000001,
                                  24'h000080, 24'h0000FF, 24'h0, 24'h0, 24'h0, 24'h0};
`ifdef VGA_SCANLINES_EN
  logic [23:0] ramp_odd  [12] = '{24'h0, 24'h0, 24'h000000, 24'h000000, 24'h000000, 24'h000000,
                                  24'h000040, 24'h00007F, 24'h0, 24'h0, 24'h0, 24'h0};
`else
  logic [23:0] ramp_odd  [12] = '{24'h0, 24'h0, 24'h000000, 24'h000000, 24'h000001, 24'h000001,
                                  24'h000080, 24'h0000FF, 24'h0, 24'h0, 24'h0, 24'h0};
`endif

  // Constant lines: 1 marks a picture column, 0 a border or blanking column.
  int flat_h   [9] = '{0, 63, 64, 65, 300, 575, 576, 639, 640};
  bit flat_pic [9] = '{0, 0, 1, 1, 1, 1, 0, 0, 0};

  task automatic expect_ramp(int v);
    for (int i = 0; i < 12; i++) push_exp(v, ramp_h[i], ramp_even[i]);
    for (int i = 0; i < 12; i++) push_exp(v + 1, ramp_h[i], ramp_odd[i]);
  endtask

  task automatic expect_flat(int v, logic [23:0] c_even, logic [23:0] c_odd);
    for (int i = 0; i < 9; i++) push_exp(v, flat_h[i], flat_pic[i] ? c_even : 24'h0);
    for (int i = 0; i < 9; i++) push_exp(v + 1, flat_h[i], flat_pic[i] ? c_odd : 24'h0);
  endtask

  // ---------------------------------------------------------------- monitor
  initial begin
    int   idx;
    int   ph;
    int   pv;
    exp_t e;
    @(posedge rst_n);
    forever begin
      @(posedge clk);
      #1;
      idx = tv * 800 + th - 2;
      if (rst_n && idx >= 0) begin
        ph = idx % 800;
        pv = idx / 800;
        check("hsync", pv, ph, 32'(hs), 32'(!(ph >= 656 && ph <= 751)));
        check("vsync", pv, ph, 32'(vs), 32'(!(pv >= 490 && pv <= 491)));
        check("de", pv, ph, 32'(de), 32'(ph < 640 && pv < 480));
        if (!(ph < 640 && pv < 480)) check("blank_rgb", pv, ph, 32'(rgb), 32'h0);
        while (exp_q.size() > 0 && (exp_q[0].v * 800 + exp_q[0].h) < idx) begin
          e = exp_q.pop_front();
          check("missed_expect", e.v, e.h, 32'(idx), 32'(e.v * 800 + e.h));
        end
        if (exp_q.size() > 0 && exp_q[0].v == pv && exp_q[0].h == ph) begin
          e = exp_q.pop_front();
          check("pix_rgb", pv, ph, 32'(rgb), 32'(e.rgb));
          check("pix_de", pv, ph, 32'(de), 32'(e.de));
        end
      end
    end
  end

  // ---------------------------------------------------------------- driver
  task automatic wait_pos(int v, int h);
    int guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!(tv == v && th == h) && guard < 20000);
    if (guard >= 20000) check("wait_pos_timeout", v, h, 32'(guard), 32'd0);
  endtask

  task automatic drive_line(int v, int h, bit ramp, logic [23:0] c);
    wait_pos(v, h);
    for (int x = 0; x < 256; x++) begin
      pix.valid = 1'b1;
      pix.x     = 9'(x);
      pix.rgb   = ramp ? {16'h0000, 8'(x)} : c;
      @(negedge clk);
    end
    pix.valid = 1'b0;
  endtask

  initial begin
    #(40 * 30000);
    $display("FAIL watchdog expired before end of test");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    pix.valid = 1'b0;
    pix.x     = '0;
    pix.rgb   = '0;
    repeat (5) @(negedge clk);
    check("rst_hsync", 0, 0, 32'(hs), 32'd1);
    check("rst_vsync", 0, 0, 32'(vs), 32'd1);
    check("rst_de", 0, 0, 32'(de), 32'd0);
    check("rst_rgb", 0, 0, 32'(rgb), 32'h0);
    check("rst_overrun", 0, 0, 32'(ovr), 32'd0);
    rst_n = 1'b1;

    // Ramp into bank 0, shown on lines 2/3.
    expect_ramp(2);
    drive_line(0, 100, 1'b1, 24'h0);
    check("overrun_idle", tv, th, 32'(ovr), 32'd0);

    // Line A completes during line 3 and appears on 4/5; line B completes
    // mid-line 4 but line 5 must still show A, and B arrives on line 6.
`ifdef VGA_SCANLINES_EN
    expect_flat(4, 24'h112233, 24'h081119);
`else
    expect_flat(4, 24'h112233, 24'h112233);
`endif
    drive_line(3, 100, 1'b0, 24'h112233);
`ifdef VGA_SCANLINES_EN
    expect_flat(6, 24'h445566, 24'h222A33);
`else
    expect_flat(6, 24'h445566, 24'h445566);
`endif
    drive_line(4, 200, 1'b0, 24'h445566);

    // Out-of-range pixel: sticky flag, no write and no bank flip.
    wait_pos(6, 50);
    pix.valid = 1'b1;
    pix.x     = 9'd300;
    pix.rgb   = 24'hFFFFFF;
    @(negedge clk);
    pix.valid = 1'b0;
    @(negedge clk);
    check("overrun_set", tv, th, 32'(ovr), 32'd1);

`ifdef VGA_SCANLINES_EN
    expect_flat(8, 24'hFF80FE, 24'h7F407F);
`else
    expect_flat(8, 24'hFF80FE, 24'hFF80FE);
`endif
    drive_line(7, 100, 1'b0, 24'hFF80FE);

    wait_pos(10, 10);
    check("queue_drained", tv, th, 32'(exp_q.size()), 32'd0);
    check("overrun_sticky", tv, th, 32'(ovr), 32'd1);

    rst_n = 1'b0;
    #1;
    check("rst2_overrun", 0, 0, 32'(ovr), 32'd0);
    check("rst2_de", 0, 0, 32'(de), 32'd0);
    check("rst2_hsync", 0, 0, 32'(hs), 32'd1);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
